bin2bcd_seq: RTL and testbench

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method. It sits between the 14-bit event counter (value 0..9999) and the 4-digit multiplexed 7-segment display driver. It turns the counter's binary value into packed BCD digits plus a leading-zero blanking mask for the display. It performs one shift iteration per enabled clock, which keeps logic small for the FPGA board design.

---
 rtl/bin2bcd_seq.sv | 131 +++++++++++++
 tb/tb_bin2bcd_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary-to-BCD converter with leading-zero blanking
module bin2bcd_seq #(
    parameter int BITS_NUM = 14,
    parameter int DIGITS   = 4
) (
    input  logic                  CLK,
    input  logic                  CLR,
    input  logic                  CE,
    input  logic                  START,
    input  logic [BITS_NUM-1:0]   BIN,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [4*DIGITS-1:0]   BCD,
    output logic [DIGITS-1:0]     BLANK,
    output logic                  OVF
);

    localparam int SW    = 4 * DIGITS;
    localparam int CNT_W = $clog2(BITS_NUM + 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SHIFT   = 2'd1;
    localparam logic [1:0] DONE_ST = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BITS_NUM);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Largest displayable value plus one; anything at or above saturates.
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    localparam logic [63:0] LIMIT      = pow10(DIGITS);
    localparam logic [SW-1:0]     ALL_NINES  = {DIGITS{4'h9}};
    localparam logic [DIGITS-1:0] BLANK_RST  = {{(DIGITS-1){1'b1}}, 1'b0};

    logic [1:0]            state;
    logic [BITS_NUM-1:0]   bin_reg;
    logic [SW-1:0]         scratch;
    logic [CNT_W-1:0]      cnt;
    logic                  ovf_pending;

    logic [SW-1:0]         adj;
    logic [SW+BITS_NUM-1:0] shifted;
    logic [SW-1:0]         scratch_next;
    logic [BITS_NUM-1:0]   bin_next;
    logic [SW-1:0]         bcd_new;
    logic [DIGITS-1:0]     blank_new;
    logic                  bin_ovf;
    logic                  upper_zero;

    assign bin_ovf = (64'(BIN) >= LIMIT);

    // One double-dabble step: add 3 to every nibble >= 5, then shift the whole chain left.
    always_comb begin
        adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end else begin
                adj[4*i +: 4] = scratch[4*i +: 4];
            end
        end
        shifted      = {adj, bin_reg} << 1;
        scratch_next = shifted[SW+BITS_NUM-1 : BITS_NUM];
        bin_next     = shifted[BITS_NUM-1:0];
    end

    // Final value and blanking mask that get loaded on the last iteration.
    always_comb begin
        bcd_new    = ovf_pending ? ALL_NINES : scratch_next;
        blank_new  = '0;
        upper_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            upper_zero   = upper_zero & (bcd_new[4*i +: 4] == 4'd0);
            blank_new[i] = upper_zero;
        end
    end

    // Control FSM, shift datapath and output registers; everything freezes when CE is low.
    always_ff @(posedge CLK) begin
        if (!CLR) begin
            state       <= IDLE;
            bin_reg     <= '0;
            scratch     <= '0;
            cnt         <= '0;
            ovf_pending <= 1'b0;
            BCD         <= '0;
            BLANK       <= BLANK_RST;
            OVF         <= 1'b0;
        end else if (CE) begin
            case (state)
                IDLE: begin
                    if (START) begin
                        bin_reg     <= BIN;
                        scratch     <= '0;
                        cnt         <= CNT_LOAD;
                        ovf_pending <= bin_ovf;
                        state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    bin_reg <= bin_next;
                    scratch <= scratch_next;
                    cnt     <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state <= DONE_ST;
                        BCD   <= bcd_new;
                        BLANK <= blank_new;
                        OVF   <= ovf_pending;
                    end
                end
                DONE_ST: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign BUSY = (state == SHIFT);
    assign DONE = (state == DONE_ST);

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - randomized self-checking bench for bin2bcd_seq
module tb_bin2bcd_seq;

    logic        CLK;
    logic        CLR;
    logic        CE;
    logic        START;
    logic [13:0] BIN;
    logic        BUSY;
    logic        DONE;
    logic [15:0] BCD;
    logic [3:0]  BLANK;
    logic        OVF;

    int n_cmp = 0;
    int n_err = 0;

    bin2bcd_seq #(.BITS_NUM(14), .DIGITS(4)) dut (
        .CLK   (CLK),
        .CLR   (CLR),
        .CE    (CE),
        .START (START),
        .BIN   (BIN),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .BCD   (BCD),
        .BLANK (BLANK),
        .OVF   (OVF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic int sat(input int v);
        return (v > 9999) ? 9999 : v;
    endfunction

    function automatic logic [15:0] model_bcd(input int v);
        logic [15:0] r;
        int s;
        s = sat(v);
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(s % 10);
            s = s / 10;
        end
        return r;
    endfunction

    function automatic logic [3:0] model_blank(input int v);
        logic [3:0] b;
        int s;
        int p;
        s = sat(v);
        b = '0;
        p = 10;
        for (int i = 1; i < 4; i++) begin
            b[i] = (s < p);
            p = p * 10;
        end
        return b;
    endfunction

    function automatic logic model_ovf(input int v);
        return v > 9999;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_conv(input int v);
        CE    = 1'b1;
        CLR   = 1'b1;
        BIN   = 14'(v);
        START = 1'b1;
        step();
        START = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!DONE && cycles < 200) begin
            step();
            cycles++;
        end
    endtask

    task automatic test_reset();
        CLR = 1'b0; CE = 1'b1; START = 1'b1; BIN = 14'd123;
        step();
        step();
        n_cmp++; if (BCD !== 16'h0000) begin n_err++; $display("FAIL reset_bcd got %h want 0000", BCD); end
        n_cmp++; if (BLANK !== 4'b1110) begin n_err++; $display("FAIL reset_blank got %b want 1110", BLANK); end
        n_cmp++; if (OVF !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", OVF); end
        n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", BUSY); end
        n_cmp++; if (DONE !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", DONE); end
        step();
        n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL reset_start_busy got %b want 0", BUSY); end
        START = 1'b0;
        CLR   = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int cycles;
        start_conv(1234);
        cycles = 0;
        while (BUSY && cycles < 100) begin
            cycles++;
            step();
        end
        n_cmp++; if (cycles !== 14) begin n_err++; $display("FAIL basic_busy_len got %0d want 14", cycles); end
        n_cmp++; if (DONE !== 1'b1) begin n_err++; $display("FAIL basic_done got %b want 1", DONE); end
        n_cmp++; if (BCD !== 16'h1234) begin n_err++; $display("FAIL basic_bcd got %h want 1234", BCD); end
        n_cmp++; if (BLANK !== 4'b0000) begin n_err++; $display("FAIL basic_blank got %b want 0000", BLANK); end
        n_cmp++; if (OVF !== 1'b0) begin n_err++; $display("FAIL basic_ovf got %b want 0", OVF); end
        step();
        n_cmp++; if (DONE !== 1'b0 || BUSY !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse got done=%b busy=%b want 0 0", DONE, BUSY); end
        n_cmp++; if (BCD !== 16'h1234) begin n_err++; $display("FAIL basic_hold got %h want 1234", BCD); end
    endtask

    task automatic test_values();
        int vals[$];
        int cycles;
        vals = '{0, 7, 42, 9999, 10000, 12000, 16383, 5};
        for (int i = 0; i < 24; i++) vals.push_back(int'($urandom_range(0, 16383)));
        foreach (vals[i]) begin
            start_conv(vals[i]);
            wait_done(cycles);
            n_cmp++; if (cycles !== 14) begin n_err++; $display("FAIL val_latency v=%0d got %0d want 14", vals[i], cycles); end
            n_cmp++; if (BCD !== model_bcd(vals[i])) begin n_err++; $display("FAIL val_bcd v=%0d got %h want %h", vals[i], BCD, model_bcd(vals[i])); end
            n_cmp++; if (BLANK !== model_blank(vals[i])) begin n_err++; $display("FAIL val_blank v=%0d got %b want %b", vals[i], BLANK, model_blank(vals[i])); end
            n_cmp++; if (OVF !== model_ovf(vals[i])) begin n_err++; $display("FAIL val_ovf v=%0d got %b want %b", vals[i], OVF, model_ovf(vals[i])); end
            step();
        end
    endtask

    task automatic test_ignore_start();
        int cycles;
        start_conv(500);
        repeat (4) step();
        BIN   = 14'd777;
        START = 1'b1;
        step();
        START = 1'b0;
        BIN   = 14'd3333;
        wait_done(cycles);
        n_cmp++; if (cycles !== 9) begin n_err++; $display("FAIL ign_latency got %0d want 9", cycles); end
        n_cmp++; if (BCD !== model_bcd(500)) begin n_err++; $display("FAIL ign_bcd got %h want %h", BCD, model_bcd(500)); end
        START = 1'b1;
        step();
        START = 1'b0;
        n_cmp++; if (BUSY !== 1'b0 || DONE !== 1'b0) begin n_err++; $display("FAIL ign_done_start got busy=%b done=%b want 0 0", BUSY, DONE); end
    endtask

    task automatic test_ce_toggle();
        int cycles;
        int v;
        v = int'($urandom_range(0, 9999));
        start_conv(v);
        cycles = 0;
        while (BUSY && cycles < 200) begin
            cycles++;
            CE = ~CE;
            step();
        end
        n_cmp++; if (cycles !== 28) begin n_err++; $display("FAIL ce_busy_len got %0d want 28", cycles); end
        n_cmp++; if (DONE !== 1'b1) begin n_err++; $display("FAIL ce_done got %b want 1", DONE); end
        CE = 1'b0;
        step();
        n_cmp++; if (DONE !== 1'b1) begin n_err++; $display("FAIL ce_done_stretch got %b want 1", DONE); end
        CE = 1'b1;
        step();
        n_cmp++; if (DONE !== 1'b0) begin n_err++; $display("FAIL ce_done_end got %b want 0", DONE); end
        n_cmp++; if (BCD !== model_bcd(v)) begin n_err++; $display("FAIL ce_bcd v=%0d got %h want %h", v, BCD, model_bcd(v)); end
        n_cmp++; if (BLANK !== model_blank(v)) begin n_err++; $display("FAIL ce_blank v=%0d got %b want %b", v, BLANK, model_blank(v)); end
    endtask

    task automatic test_reset_mid();
        int cycles;
        int seen_done;
        start_conv(8888);
        repeat (6) step();
        CLR = 1'b0;
        step();
        n_cmp++; if (BUSY !== 1'b0 || DONE !== 1'b0) begin n_err++; $display("FAIL mid_state got busy=%b done=%b want 0 0", BUSY, DONE); end
        n_cmp++; if (BCD !== 16'h0000) begin n_err++; $display("FAIL mid_bcd got %h want 0000", BCD); end
        n_cmp++; if (BLANK !== 4'b1110) begin n_err++; $display("FAIL mid_blank got %b want 1110", BLANK); end
        CLR = 1'b1;
        seen_done = 0;
        repeat (20) begin
            step();
            if (DONE === 1'b1 || BUSY === 1'b1) seen_done++;
        end
        n_cmp++; if (seen_done !== 0) begin n_err++; $display("FAIL mid_no_done got %0d want 0", seen_done); end
        start_conv(3050);
        wait_done(cycles);
        n_cmp++; if (cycles !== 14) begin n_err++; $display("FAIL mid_latency got %0d want 14", cycles); end
        n_cmp++; if (BCD !== 16'h3050) begin n_err++; $display("FAIL mid_bcd2 got %h want 3050", BCD); end
        n_cmp++; if (BLANK !== 4'b0000) begin n_err++; $display("FAIL mid_blank2 got %b want 0000", BLANK); end
        step();
    endtask

    initial begin
        CLR = 1'b0; CE = 1'b0; START = 1'b0; BIN = '0;
        #2;
        test_reset();
        test_basic();
        test_values();
        test_ignore_start();
        test_ce_toggle();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
